// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, register selects, instruction layout and sequencer states.
package alu_pkg;
    localparam int INSTR_W = 17;

    // Instruction field offsets: [16] load, [15] cin, [14:12] reg_sel, [11:8] op, [7:0] data.
    localparam int F_LOAD   = 16;
    localparam int F_CIN    = 15;
    localparam int F_SEL_LO = 12;
    localparam int F_OP_LO  = 8;
    localparam int F_DATA   = 0;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_LSHIFT = 4'h2;
    localparam logic [3:0] OP_RSHIFT = 4'h3;
    localparam logic [3:0] OP_XOR    = 4'h4;
    localparam logic [3:0] OP_CMP    = 4'h5;
    localparam logic [3:0] OP_AND    = 4'h6;
    localparam logic [3:0] OP_NAND   = 4'h7;
    localparam logic [3:0] OP_OR     = 4'h8;
    localparam logic [3:0] OP_NOR    = 4'h9;
    localparam logic [3:0] OP_CPY    = 4'hA;

    localparam logic [2:0] SEL_ACCU = 3'b000;
    localparam logic [2:0] SEL_REG0 = 3'b001;
    localparam logic [2:0] SEL_REG1 = 3'b010;
    localparam logic [2:0] SEL_REG2 = 3'b011;
    localparam logic [2:0] SEL_REG3 = 3'b100;
    localparam logic [2:0] SEL_REG4 = 3'b101;
    localparam logic [2:0] SEL_REG5 = 3'b110;
    localparam logic [2:0] SEL_REG6 = 3'b111;

    typedef struct packed {
        logic       load;
        logic       cin;
        logic [2:0] reg_sel;
        logic [3:0] op;
        logic [7:0] data;
    } instr_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;
endpackage

// File: rtl/alu_program_sequencer_ram.sv
// seq_prog_ram: DEPTH x 17 program store, synchronous write, asynchronous read.
//   clk, we/waddr/wdata : write port
//   raddr -> rdata       : combinational read port
module seq_prog_ram
    import alu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [INSTR_W-1:0] rdata
);
    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/alu_program_sequencer.sv
// alu_program_sequencer: steps a host-written program through the CPU control port, 2 cycles per instruction.
//   prog_we/prog_addr/prog_data : program RAM write (honoured only in IDLE)
//   start/len                   : run request, sampled in IDLE; busy/done report progress
//   cpu_*                       : registered CPU control outputs and CPU response inputs
//   res_valid/res_data/res_cout/res_index : one strobe per executed instruction
module alu_program_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [AW-1:0]      prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic [AW:0]        len,
    output logic               busy,
    output logic               done,
    output logic [6:0]         cpu_opcode,
    output logic [7:0]         cpu_data_in,
    output logic               cpu_cin,
    output logic               cpu_load,
    output logic               cpu_ce,
    input  logic [7:0]         cpu_data_out,
    input  logic               cpu_cout,
    output logic               res_valid,
    output logic [7:0]         res_data,
    output logic               res_cout,
    output logic [AW-1:0]      res_index
);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t             state, state_n;
    logic [AW-1:0]      pc, pc_n;
    logic [AW:0]        len_q, len_n;
    logic [INSTR_W-1:0] ram_rd;
    instr_t             ins;
    logic               ram_we, last;
    logic               busy_n, done_n, ce_n, load_n, cin_n, res_valid_n, res_cout_n;
    logic [6:0]         opcode_n;
    logic [7:0]         data_in_n, res_data_n;
    logic [AW-1:0]      res_index_n;

    assign ram_we = prog_we && state == S_IDLE;

    seq_prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_n),
        .rdata (ram_rd)
    );

    // Outputs are registered at the edge entering ISSUE, so a word written on that same edge
    // is forwarded straight from the write port.
    assign ins  = instr_t'((ram_we && prog_addr == pc_n) ? prog_data : ram_rd);
    assign last = {1'b0, pc} == len_q - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            len_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cpu_ce      <= 1'b0;
            cpu_load    <= 1'b0;
            cpu_cin     <= 1'b0;
            cpu_opcode  <= '0;
            cpu_data_in <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_cout    <= 1'b0;
            res_index   <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            len_q       <= len_n;
            busy        <= busy_n;
            done        <= done_n;
            cpu_ce      <= ce_n;
            cpu_load    <= load_n;
            cpu_cin     <= cin_n;
            cpu_opcode  <= opcode_n;
            cpu_data_in <= data_in_n;
            res_valid   <= res_valid_n;
            res_data    <= res_data_n;
            res_cout    <= res_cout_n;
            res_index   <= res_index_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        len_n   = len_q;
        case (state)
            S_IDLE: if (start) begin
                state_n = (len == '0) ? S_DONE : S_ISSUE;
                pc_n    = '0;
                len_n   = (len > DEPTH_L) ? DEPTH_L : len;
            end
            S_ISSUE:   state_n = S_CAPTURE;
            S_CAPTURE: begin
                state_n = last ? S_DONE : S_ISSUE;
                pc_n    = last ? pc : pc + 1'b1;
            end
            default:   state_n = S_IDLE;
        endcase
    end

    // Next values for the output registers; CAPTURE holds the ISSUE control word with ce low.
    always_comb begin
        busy_n      = state_n != S_IDLE;
        done_n      = state_n == S_DONE;
        ce_n        = state_n == S_ISSUE;
        load_n      = ce_n ? ins.load : (state_n == S_CAPTURE) ? cpu_load : 1'b0;
        cin_n       = ce_n ? ins.cin : (state_n == S_CAPTURE) ? cpu_cin : 1'b0;
        opcode_n    = ce_n ? {ins.reg_sel, ins.op} : (state_n == S_CAPTURE) ? cpu_opcode : '0;
        data_in_n   = ce_n ? ins.data : (state_n == S_CAPTURE) ? cpu_data_in : '0;
        res_valid_n = state == S_CAPTURE;
        res_data_n  = res_valid_n ? cpu_data_out : res_data;
        res_cout_n  = res_valid_n ? cpu_cout : res_cout;
        res_index_n = res_valid_n ? pc : res_index;
    end
endmodule

// File: tb/tb_alu_program_sequencer.sv
// tb_alu_program_sequencer: scoreboard bench with a CPU model on the control port and a transaction-level reference.
module tb_alu_program_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, prog_we = 1'b0, start = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [16:0] prog_data = '0;
    logic [4:0]  len = '0;
    logic        busy, done, cpu_cin, cpu_load, cpu_ce, cpu_cout, res_valid, res_cout;
    logic [6:0]  cpu_opcode;
    logic [7:0]  cpu_data_in, cpu_data_out, res_data;
    logic [3:0]  res_index;

    typedef struct {
        int         idx;
        logic [7:0] d;
        logic       c;
        logic       ld;
    } exp_t;

    exp_t        exp_q[$];
    logic [16:0] mem [16];
    logic [7:0]  cr [8];
    logic [7:0]  rr [8];
    int          n_chk = 0, n_fail = 0, res_cnt = 0, ce_cnt = 0;

    alu_program_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .len(len), .busy(busy), .done(done),
        .cpu_opcode(cpu_opcode), .cpu_data_in(cpu_data_in), .cpu_cin(cpu_cin),
        .cpu_load(cpu_load), .cpu_ce(cpu_ce), .cpu_data_out(cpu_data_out), .cpu_cout(cpu_cout),
        .res_valid(res_valid), .res_data(res_data), .res_cout(res_cout), .res_index(res_index)
    );

    always #5 clk = ~clk;

    // ALU semantics: SUB reports borrow in cout, shifts move cin in and the dropped bit out,
    // CMP leaves ACCU alone and flags a < b.
    function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
        case (op)
            OP_ADD:    alu = {1'b0, a} + {1'b0, b} + {8'b0, c};
            OP_SUB:    alu = {1'b0, a} - {1'b0, b} - {8'b0, c};
            OP_LSHIFT: alu = {a, c};
            OP_RSHIFT: alu = {a[0], c, a[7:1]};
            OP_XOR:    alu = {1'b0, a ^ b};
            OP_CMP:    alu = {a < b, a};
            OP_AND:    alu = {1'b0, a & b};
            OP_NAND:   alu = {1'b0, ~(a & b)};
            OP_OR:     alu = {1'b0, a | b};
            OP_NOR:    alu = {1'b0, ~(a | b)};
            OP_CPY:    alu = {1'b0, b};
            default:   alu = 9'h0;
        endcase
    endfunction

    function automatic logic [16:0] ins(input logic ld, input logic c, input logic [2:0] sel, input logic [3:0] op, input logic [7:0] d);
        ins = {ld, c, sel, op, d};
    endfunction

    // CPU stand-in: acts on the edge where ce is high, result visible the following cycle.
    always @(posedge clk) begin
        logic [8:0] r;
        if (rst) begin
            for (int i = 0; i < 8; i++) cr[i] <= '0;
            cpu_data_out <= '0;
            cpu_cout     <= 1'b0;
        end else if (cpu_ce) begin
            if (cpu_load) begin
                cr[cpu_opcode[6:4]] <= cpu_data_in;
                cpu_data_out        <= cpu_data_in;
                cpu_cout            <= 1'b0;
            end else begin
                r = alu(cpu_opcode[3:0], cr[0], cr[cpu_opcode[6:4]], cpu_cin);
                if (cpu_opcode[3:0] != OP_CMP) cr[0] <= r[7:0];
                cpu_data_out <= r[7:0];
                cpu_cout     <= r[8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cpu_ce) ce_cnt++;
        if (res_valid) begin
            res_cnt++;
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("res_index", res_index, e.idx);
                if (!e.ld) begin
                    chk("res_data", res_data, e.d);
                    chk("res_cout", res_cout, e.c);
                end
            end
        end
    end

    // Reference: execute the first n program words in order against a register-file model.
    task automatic model(input int n);
        logic [16:0] w;
        logic [8:0]  r;
        for (int i = 0; i < n; i++) begin
            w = mem[i];
            if (w[F_LOAD]) begin
                rr[w[14:12]] = w[7:0];
                exp_q.push_back('{i, w[7:0], 1'b0, 1'b1});
            end else begin
                r = alu(w[11:8], rr[0], rr[w[14:12]], w[F_CIN]);
                if (w[11:8] != OP_CMP) rr[0] = r[7:0];
                exp_q.push_back('{i, r[7:0], r[8], 1'b0});
            end
        end
    endtask

    task automatic wr(input int a, input logic [16:0] d);
        prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
        @(posedge clk) #1;
        prog_we = 1'b0;
        mem[a] = d;
    endtask

    task automatic rand_prog();
        for (int i = 0; i < 16; i++)
            wr(i, ins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      4'($urandom_range(0, 10)), 8'($urandom_range(0, 255))));
    endtask

    // mode 0: plain run; 1: start and prog_we poked while busy (both must be ignored);
    // 2: word w written to address 0 on the same edge that accepts start.
    task automatic run(input int l, input int mode, input logic [16:0] w);
        int n, cyc, rc0, cc0;
        n = l > 16 ? 16 : l;
        if (mode == 2) begin
            prog_we = 1'b1; prog_addr = '0; prog_data = w; mem[0] = w;
        end
        model(n);
        rc0 = res_cnt; cc0 = ce_cnt;
        start = 1'b1; len = 5'(l);
        @(posedge clk) #1;
        start = 1'b0; prog_we = 1'b0; cyc = 1;
        while (!done && cyc < 100) begin
            if (mode == 1 && cyc == 2) begin
                start = 1'b1; len = 5'd1; prog_we = 1'b1; prog_addr = '0; prog_data = ~mem[0];
            end else begin
                start = 1'b0; prog_we = 1'b0;
            end
            @(posedge clk) #1;
            cyc++;
        end
        start = 1'b0; prog_we = 1'b0;
        chk("done_latency", cyc, n == 0 ? 1 : 2 * n + 1);
        @(posedge clk) #1;
        chk("busy_after_done", busy, 0);
        chk("result_count", res_cnt - rc0, n);
        chk("queue_drained", exp_q.size(), 0);
        if (n == 0) chk("ce_with_len0", ce_cnt - cc0, 0);
    endtask

    initial begin
        int dc;
        for (int i = 0; i < 8; i++) rr[i] = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ce", cpu_ce, 0);
        chk("rst_load", cpu_load, 0);
        chk("rst_cin", cpu_cin, 0);
        chk("rst_opcode", cpu_opcode, 0);
        chk("rst_data_in", cpu_data_in, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_cout", res_cout, 0);
        chk("rst_res_index", res_index, 0);
        rst = 1'b0;
        @(posedge clk) #1;

        // ACCU<=1, REG0<=2, ACCU+REG0 -> 3
        wr(0, ins(1'b1, 1'b0, SEL_ACCU, OP_ADD, 8'd1));
        wr(1, ins(1'b1, 1'b0, SEL_REG0, OP_ADD, 8'd2));
        wr(2, ins(1'b0, 1'b0, SEL_REG0, OP_ADD, 8'd0));
        run(3, 0, '0);

        // ACCU=3, ACCU-ACCU -> 0
        wr(0, ins(1'b1, 1'b0, SEL_ACCU, OP_ADD, 8'd3));
        wr(1, ins(1'b0, 1'b0, SEL_ACCU, OP_SUB, 8'd0));
        run(2, 0, '0);

        // ACCU=3 -> 0x06 -> 0x0D -> 0x86
        wr(1, ins(1'b0, 1'b0, SEL_ACCU, OP_LSHIFT, 8'd0));
        wr(2, ins(1'b0, 1'b1, SEL_ACCU, OP_LSHIFT, 8'd0));
        wr(3, ins(1'b0, 1'b1, SEL_ACCU, OP_RSHIFT, 8'd0));
        run(4, 0, '0);

        run(0, 0, '0);

        run(3, 2, ins(1'b1, 1'b0, SEL_ACCU, OP_ADD, 8'h55));

        rand_prog();
        run(17, 0, '0);

        run(5, 1, '0);
        run(5, 0, '0);

        // Reset during the second ISSUE of a 4-instruction run.
        model(4);
        start = 1'b1; len = 5'd4;
        @(posedge clk) #1;
        start = 1'b0;
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) rr[i] = '0;
        chk("abort_ce", cpu_ce, 0);
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        dc = 0;
        repeat (6) begin
            @(posedge clk) #1;
            dc += int'(done);
        end
        chk("abort_no_done", dc, 0);
        run(4, 0, '0);

        for (int k = 0; k < 15; k++) begin
            rand_prog();
            run($urandom_range(0, 17), 0, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
